// File: rtl/axis_frame_fifo.sv
// Store-and-forward AXI-Stream frame FIFO.
// Only complete good frames reach the output; bad or unfittable frames are dropped whole.
module axis_frame_fifo #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 8,
  parameter int DROP_WHEN_FULL = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser,
  output logic                  overflow,
  output logic                  bad_frame,
  output logic                  good_frame
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic DROP_FULL = (DROP_WHEN_FULL != 0);

  logic [DATA_WIDTH:0] mem_q [0:(2**ADDR_WIDTH)-1];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] cur_ptr_q, cur_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          drop_q, drop_d;
  logic          ovf_q, ovf_d;
  logic          bad_q, bad_d;
  logic          good_q, good_d;
  logic          ovld_q, ovld_d;
  logic [DATA_WIDTH-1:0] odata_q;
  logic          olast_q;

  logic full, full_cur, empty, no_room;
  logic in_fire, wr_en, rd_en;

  assign full     = (cur_ptr_q - rd_ptr_q) == DEPTH;
  assign full_cur = (cur_ptr_q - wr_ptr_q) == DEPTH;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign no_room  = full | full_cur;

  // full_cur keeps tready high so an oversized frame drains instead of deadlocking
  assign input_axis_tready = !full | DROP_FULL | drop_q | full_cur;
  assign in_fire = input_axis_tvalid & input_axis_tready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    cur_ptr_d = cur_ptr_q;
    drop_d    = drop_q;
    ovf_d     = 1'b0;
    bad_d     = 1'b0;
    good_d    = 1'b0;
    wr_en     = 1'b0;
    if (in_fire) begin
      if (!drop_q && no_room) begin
        drop_d    = 1'b1;
        cur_ptr_d = wr_ptr_q;
      end else if (!drop_q) begin
        wr_en     = 1'b1;
        cur_ptr_d = cur_ptr_q + 1'b1;
      end
      if (input_axis_tlast) begin
        drop_d = 1'b0;
        if (drop_q || no_room) begin
          ovf_d = 1'b1;
        end else if (input_axis_tuser) begin
          cur_ptr_d = wr_ptr_q;
          bad_d     = 1'b1;
        end else begin
          wr_ptr_d = cur_ptr_q + 1'b1;
          good_d   = 1'b1;
        end
      end
    end
  end

  assign rd_en = (!ovld_q | output_axis_tready) & !empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    ovld_d   = ovld_q;
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      ovld_d   = 1'b1;
    end else if (output_axis_tready) begin
      ovld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[cur_ptr_q[ADDR_WIDTH-1:0]] <= {input_axis_tlast, input_axis_tdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      cur_ptr_q <= '0;
      rd_ptr_q  <= '0;
      drop_q    <= 1'b0;
      ovf_q     <= 1'b0;
      bad_q     <= 1'b0;
      good_q    <= 1'b0;
      ovld_q    <= 1'b0;
      odata_q   <= '0;
      olast_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cur_ptr_q <= cur_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      drop_q    <= drop_d;
      ovf_q     <= ovf_d;
      bad_q     <= bad_d;
      good_q    <= good_d;
      ovld_q    <= ovld_d;
      if (rd_en) begin
        {olast_q, odata_q} <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
      end
    end
  end

  assign output_axis_tdata  = odata_q;
  assign output_axis_tvalid = ovld_q;
  assign output_axis_tlast  = olast_q;
  assign output_axis_tuser  = 1'b0;
  assign overflow           = ovf_q;
  assign bad_frame          = bad_q;
  assign good_frame         = good_q;

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Directed bench for axis_frame_fifo: three instances share stimulus,
// sel picks the one each scenario observes.
module tb_axis_frame_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] in_data;
  logic       in_valid, in_last, in_user, out_ready;

  logic       ir0, ov0, ol0, ou0, of0, bf0, gf0;
  logic       ir1, ov1, ol1, ou1, of1, bf1, gf1;
  logic       ir2, ov2, ol2, ou2, of2, bf2, gf2;
  logic [7:0] od0, od1, od2;

  axis_frame_fifo #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .DROP_WHEN_FULL(0)) dut0 (
    .clk(clk), .rst(rst),
    .input_axis_tdata(in_data), .input_axis_tvalid(in_valid),
    .input_axis_tready(ir0), .input_axis_tlast(in_last),
    .input_axis_tuser(in_user),
    .output_axis_tdata(od0), .output_axis_tvalid(ov0),
    .output_axis_tready(out_ready), .output_axis_tlast(ol0),
    .output_axis_tuser(ou0),
    .overflow(of0), .bad_frame(bf0), .good_frame(gf0));

  axis_frame_fifo #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .DROP_WHEN_FULL(0)) dut1 (
    .clk(clk), .rst(rst),
    .input_axis_tdata(in_data), .input_axis_tvalid(in_valid),
    .input_axis_tready(ir1), .input_axis_tlast(in_last),
    .input_axis_tuser(in_user),
    .output_axis_tdata(od1), .output_axis_tvalid(ov1),
    .output_axis_tready(out_ready), .output_axis_tlast(ol1),
    .output_axis_tuser(ou1),
    .overflow(of1), .bad_frame(bf1), .good_frame(gf1));

  axis_frame_fifo #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .DROP_WHEN_FULL(1)) dut2 (
    .clk(clk), .rst(rst),
    .input_axis_tdata(in_data), .input_axis_tvalid(in_valid),
    .input_axis_tready(ir2), .input_axis_tlast(in_last),
    .input_axis_tuser(in_user),
    .output_axis_tdata(od2), .output_axis_tvalid(ov2),
    .output_axis_tready(out_ready), .output_axis_tlast(ol2),
    .output_axis_tuser(ou2),
    .overflow(of2), .bad_frame(bf2), .good_frame(gf2));

  int sel;
  logic c_ir, c_ov, c_ol, c_ou, c_of, c_bf, c_gf;
  logic [7:0] c_od;

  always_comb begin
    c_ir = ir0; c_ov = ov0; c_ol = ol0; c_ou = ou0;
    c_of = of0; c_bf = bf0; c_gf = gf0; c_od = od0;
    case (sel)
      1: begin
        c_ir = ir1; c_ov = ov1; c_ol = ol1; c_ou = ou1;
        c_of = of1; c_bf = bf1; c_gf = gf1; c_od = od1;
      end
      2: begin
        c_ir = ir2; c_ov = ov2; c_ol = ol2; c_ou = ou2;
        c_of = of2; c_bf = bf2; c_gf = gf2; c_od = od2;
      end
      default: ;
    endcase
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ovf_cnt, bad_cnt, good_cnt, acc_cnt;
  logic [8:0] rx_q[$];
  int rx_cyc[$];
  logic [7:0] fb[8];
  logic [8:0] ex[8];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (c_ov && out_ready) begin
        rx_q.push_back({c_ol, c_od});
        rx_cyc.push_back(cyc);
      end
      if (c_of) ovf_cnt++;
      if (c_bf) bad_cnt++;
      if (c_gf) good_cnt++;
      if (in_valid && c_ir) acc_cnt++;
    end
  end

  function automatic logic [8:0] rx_at(int i);
    return (i < rx_q.size()) ? rx_q[i] : 9'h1ff;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rx_q.delete();
    rx_cyc.delete();
    ovf_cnt = 0; bad_cnt = 0; good_cnt = 0; acc_cnt = 0;
  endtask

  task automatic do_reset();
    in_valid = 0; in_last = 0; in_user = 0; in_data = 8'h00;
    rst = 1;
    step();
    rst = 0;
    clear_mon();
  endtask

  task automatic send_frame(input int n, input logic user, output int stalls);
    stalls = 0;
    in_valid = 1;
    for (int i = 0; i < n; i++) begin
      in_data = fb[i];
      in_last = (i == n - 1);
      in_user = user && (i == n - 1);
      while (!c_ir && stalls < 200) begin
        step();
        stalls++;
      end
      step();
    end
    in_valid = 0; in_last = 0; in_user = 0;
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 100 && rx_q.size() < n; i++) step();
    repeat (3) step();
  endtask

  task automatic test_reset();
    sel = 0; out_ready = 1;
    do_reset();
    checks++; if (c_ov !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", c_ov); end
    checks++; if (c_od !== 8'h00) begin errors++; $display("FAIL reset_tdata got %h want 00", c_od); end
    checks++; if (c_ol !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", c_ol); end
    checks++; if (c_ou !== 1'b0) begin errors++; $display("FAIL reset_tuser got %b want 0", c_ou); end
    checks++; if ({c_of, c_bf, c_gf} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {c_of, c_bf, c_gf}); end
    checks++; if (c_ir !== 1'b1) begin errors++; $display("FAIL reset_tready got %b want 1", c_ir); end
  endtask

  task automatic test_good_frame();
    int st;
    sel = 0; out_ready = 1;
    do_reset();
    fb = '{8'hcd, 8'hab, 8'hcd, 8'hab, 8'hcd, 8'h00, 8'h00, 8'h00};
    send_frame(5, 1'b0, st);
    checks++; if (c_ov !== 1'b0) begin errors++; $display("FAIL good_early_tvalid got %b want 0", c_ov); end
    checks++; if (c_gf !== 1'b1) begin errors++; $display("FAIL good_pulse got %b want 1", c_gf); end
    step();
    checks++; if (c_ov !== 1'b1 || c_od !== 8'hcd) begin errors++; $display("FAIL good_first got v=%b d=%h want v=1 d=cd", c_ov, c_od); end
    wait_rx(5);
    ex = '{9'h0cd, 9'h0ab, 9'h0cd, 9'h0ab, 9'h1cd, 9'h0, 9'h0, 9'h0};
    checks++; if (rx_q.size() !== 5) begin errors++; $display("FAIL good_len got %0d want 5", rx_q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (rx_at(i) !== ex[i]) begin errors++; $display("FAIL good_beat%0d got %h want %h", i, rx_at(i), ex[i]); end
    end
    checks++; if (good_cnt !== 1) begin errors++; $display("FAIL good_count got %0d want 1", good_cnt); end
  endtask

  task automatic test_bad_then_good();
    int st;
    sel = 0; out_ready = 1;
    do_reset();
    fb = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(3, 1'b1, st);
    checks++; if ({c_bf, c_of} !== 2'b10) begin errors++; $display("FAIL bad_pulse got bad/ovf=%b want 10", {c_bf, c_of}); end
    fb = '{8'h44, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(2, 1'b0, st);
    wait_rx(2);
    ex = '{9'h044, 9'h155, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0};
    checks++; if (rx_q.size() !== 2) begin errors++; $display("FAIL bad_len got %0d want 2", rx_q.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (rx_at(i) !== ex[i]) begin errors++; $display("FAIL bad_beat%0d got %h want %h", i, rx_at(i), ex[i]); end
    end
    checks++; if (bad_cnt !== 1 || good_cnt !== 1) begin errors++; $display("FAIL bad_counts got bad=%0d good=%0d want 1 1", bad_cnt, good_cnt); end
  endtask

  task automatic test_backpressure();
    int st;
    sel = 0; out_ready = 0;
    do_reset();
    fb = '{8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(4, 1'b0, st);
    step();
    for (int i = 0; i < 5; i++) begin
      checks++; if (c_ov !== 1'b1 || c_od !== 8'ha1) begin errors++; $display("FAIL bp_hold%0d got v=%b d=%h want v=1 d=a1", i, c_ov, c_od); end
      step();
    end
    out_ready = 1;
    wait_rx(4);
    ex = '{9'h0a1, 9'h0a2, 9'h0a3, 9'h1a4, 9'h0, 9'h0, 9'h0, 9'h0};
    checks++; if (rx_q.size() !== 4) begin errors++; $display("FAIL bp_len got %0d want 4", rx_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_at(i) !== ex[i]) begin errors++; $display("FAIL bp_beat%0d got %h want %h", i, rx_at(i), ex[i]); end
    end
  endtask

  task automatic test_oversize();
    int st;
    sel = 1; out_ready = 1;
    do_reset();
    fb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00};
    send_frame(6, 1'b0, st);
    checks++; if (st !== 0 || acc_cnt !== 6) begin errors++; $display("FAIL ovs_accept got stalls=%0d acc=%0d want 0 6", st, acc_cnt); end
    checks++; if (c_of !== 1'b1) begin errors++; $display("FAIL ovs_pulse got %b want 1", c_of); end
    repeat (5) step();
    checks++; if (rx_q.size() !== 0 || c_ov !== 1'b0) begin errors++; $display("FAIL ovs_empty got n=%0d v=%b want 0 0", rx_q.size(), c_ov); end
    checks++; if (ovf_cnt !== 1 || c_ir !== 1'b1) begin errors++; $display("FAIL ovs_after got ovf=%0d rdy=%b want 1 1", ovf_cnt, c_ir); end
    fb = '{8'h5a, 8'h5b, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(2, 1'b0, st);
    wait_rx(2);
    checks++; if (rx_q.size() !== 2 || rx_at(0) !== 9'h05a || rx_at(1) !== 9'h15b) begin
      errors++; $display("FAIL ovs_reuse got n=%0d %h %h want 2 05a 15b", rx_q.size(), rx_at(0), rx_at(1));
    end
  endtask

  task automatic test_full_backpressure();
    int st;
    sel = 1; out_ready = 0;
    do_reset();
    fb = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(2, 1'b0, st);
    fb = '{8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(2, 1'b0, st);
    fb = '{8'h05, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    fork
      send_frame(2, 1'b0, st);
      begin
        repeat (6) step();
        // four bytes in memory plus one already loaded into the output register
        checks++; if (acc_cnt !== 5 || c_ir !== 1'b0) begin errors++; $display("FAIL fbp_stall got acc=%0d rdy=%b want 5 0", acc_cnt, c_ir); end
        out_ready = 1;
      end
    join
    wait_rx(6);
    ex = '{9'h001, 9'h102, 9'h003, 9'h104, 9'h005, 9'h106, 9'h0, 9'h0};
    checks++; if (rx_q.size() !== 6) begin errors++; $display("FAIL fbp_len got %0d want 6", rx_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (rx_at(i) !== ex[i]) begin errors++; $display("FAIL fbp_beat%0d got %h want %h", i, rx_at(i), ex[i]); end
    end
    checks++; if (ovf_cnt !== 0 || good_cnt !== 3) begin errors++; $display("FAIL fbp_counts got ovf=%0d good=%0d want 0 3", ovf_cnt, good_cnt); end
  endtask

  task automatic test_full_drop();
    int st;
    sel = 2; out_ready = 0;
    do_reset();
    fb = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(2, 1'b0, st);
    fb = '{8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(2, 1'b0, st);
    fb = '{8'h05, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(2, 1'b0, st);
    checks++; if (st !== 0 || c_of !== 1'b1) begin errors++; $display("FAIL fdrop_pulse got stalls=%0d ovf=%b want 0 1", st, c_of); end
    repeat (3) step();
    out_ready = 1;
    wait_rx(4);
    ex = '{9'h001, 9'h102, 9'h003, 9'h104, 9'h0, 9'h0, 9'h0, 9'h0};
    checks++; if (rx_q.size() !== 4) begin errors++; $display("FAIL fdrop_len got %0d want 4", rx_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_at(i) !== ex[i]) begin errors++; $display("FAIL fdrop_beat%0d got %h want %h", i, rx_at(i), ex[i]); end
    end
    checks++; if (ovf_cnt !== 1 || good_cnt !== 2) begin errors++; $display("FAIL fdrop_counts got ovf=%0d good=%0d want 1 2", ovf_cnt, good_cnt); end
  endtask

  task automatic test_back_to_back();
    int st1, st2;
    sel = 0; out_ready = 1;
    do_reset();
    fb = '{8'h10, 8'h20, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(3, 1'b0, st1);
    fb = '{8'h40, 8'h50, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(3, 1'b0, st2);
    wait_rx(6);
    checks++; if (st1 + st2 !== 0) begin errors++; $display("FAIL b2b_stalls got %0d want 0", st1 + st2); end
    ex = '{9'h010, 9'h020, 9'h130, 9'h040, 9'h050, 9'h160, 9'h0, 9'h0};
    checks++; if (rx_q.size() !== 6) begin errors++; $display("FAIL b2b_len got %0d want 6", rx_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (rx_at(i) !== ex[i]) begin errors++; $display("FAIL b2b_beat%0d got %h want %h", i, rx_at(i), ex[i]); end
    end
    if (rx_cyc.size() == 6) begin
      checks++; if (rx_cyc[5] - rx_cyc[0] !== 5) begin errors++; $display("FAIL b2b_rate got span=%0d want 5", rx_cyc[5] - rx_cyc[0]); end
    end
    checks++; if (good_cnt !== 2) begin errors++; $display("FAIL b2b_good got %0d want 2", good_cnt); end
  endtask

  task automatic test_reset_midframe();
    int st;
    sel = 0; out_ready = 0;
    do_reset();
    fb = '{8'h61, 8'h62, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(2, 1'b0, st);
    step();
    in_valid = 1; in_last = 0; in_data = 8'h63;
    step();
    in_data = 8'h64;
    step();
    in_valid = 0;
    rst = 1;
    step();
    checks++; if (c_ov !== 1'b0 || c_od !== 8'h00 || c_ol !== 1'b0) begin
      errors++; $display("FAIL rstmid_out got v=%b d=%h l=%b want 0 00 0", c_ov, c_od, c_ol);
    end
    checks++; if ({c_of, c_bf, c_gf} !== 3'b000) begin errors++; $display("FAIL rstmid_pulses got %b want 000", {c_of, c_bf, c_gf}); end
    rst = 0;
    clear_mon();
    out_ready = 1;
    repeat (6) step();
    checks++; if (rx_q.size() !== 0 || c_ov !== 1'b0) begin errors++; $display("FAIL rstmid_idle got n=%0d v=%b want 0 0", rx_q.size(), c_ov); end
    fb = '{8'h77, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(2, 1'b0, st);
    wait_rx(2);
    checks++; if (rx_q.size() !== 2 || rx_at(0) !== 9'h077 || rx_at(1) !== 9'h188) begin
      errors++; $display("FAIL rstmid_new got n=%0d %h %h want 2 077 188", rx_q.size(), rx_at(0), rx_at(1));
    end
  endtask

  initial begin
    rst = 1; in_valid = 0; in_last = 0; in_user = 0;
    in_data = 8'h00; out_ready = 0; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_good_frame();
    test_bad_then_good();
    test_backpressure();
    test_oversize();
    test_full_backpressure();
    test_full_drop();
    test_back_to_back();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
